// File: rtl/ram_pkg.sv
// Shared definitions for the ram_sync block: controller states and lane helpers.
package ram_pkg;

    // Controller states: sweeping the array to the fill value, or serving requests.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

    // Number of independently writable lanes in one word.
    function automatic int lanes_of(input int data_bits, input int lane_bits);
        return data_bits / lane_bits;
    endfunction

    // True when a word splits into a whole number of lanes.
    function automatic bit lanes_divide(input int data_bits, input int lane_bits);
        return (lane_bits > 0) && (data_bits % lane_bits == 0);
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once writing the fill value,
// then parks in IDLE with ready high until the next reset.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int addr_bits = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 clear_we,
    output logic [addr_bits-1:0] clear_addr,
    output logic                 ready,
    output logic                 busy
);

    localparam logic [addr_bits-1:0] last_addr = '1;

    ram_state_t state;

    // Single-process FSM with registered outputs; the sweep ends on the edge that writes the last address.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= CLEAR;
            clear_addr <= '0;
            clear_we   <= 1'b1;
            ready      <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (clear_addr == last_addr) begin
                        state    <= IDLE;
                        clear_we <= 1'b0;
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        clear_addr <= clear_addr + 1'b1;
                    end
                end
                IDLE: begin
                    clear_we <= 1'b0;
                    ready    <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_sync.sv
// Single-port clocked-read RAM with per-lane write masking and a req/ready handshake.
// Define RAM_INIT_CLEAR_EN to build the post-reset clear sweep (ram_clear_ctrl);
// without it the block is ready immediately and initial contents are unspecified.
module ram_sync
    import ram_pkg::*;
#(
    parameter int                   addr_bits  = 16,
    parameter int                   data_bits  = 8,
    parameter int                   lane_bits  = 8,
    parameter logic [data_bits-1:0] fill_value = '0
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        req,
    input  logic                                        write_enable,
    input  logic [addr_bits-1:0]                        address,
    input  logic [data_bits-1:0]                        data_in,
    input  logic [lanes_of(data_bits, lane_bits)-1:0]   write_mask,
    output logic                                        ready,
    output logic                                        busy,
    output logic [data_bits-1:0]                        data_out,
    output logic                                        data_valid
);

    localparam int lanes = lanes_of(data_bits, lane_bits);
    localparam int depth = 1 << addr_bits;

    if (!lanes_divide(data_bits, lane_bits)) begin : g_lane_check
        $error("ram_sync: data_bits must be a multiple of lane_bits");
    end

    logic [data_bits-1:0] mem [depth];
    logic                 clear_we;
    logic [addr_bits-1:0] clear_addr;
    logic                 accept;

`ifdef RAM_INIT_CLEAR_EN
    ram_clear_ctrl #(
        .addr_bits (addr_bits)
    ) u_clear_ctrl (
        .clock      (clock),
        .reset      (reset),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .ready      (ready),
        .busy       (busy)
    );
`else
    assign clear_we   = 1'b0;
    assign clear_addr = '0;
    assign ready      = 1'b1;
    assign busy       = 1'b0;
`endif

    // With ready low the AND is forced to 0, so undriven request pins cannot reach the array.
    assign accept = req && ready && !reset;

    // Array write port: the clear sweep owns it while busy, otherwise masked lane writes.
    // NOTE: the memory array has no reset branch; clearing is the sweep's job, and a reset here would block RAM inference.
    always_ff @(posedge clock) begin
        if (clear_we) begin
            mem[clear_addr] <= fill_value;
        end else if (accept && write_enable) begin
            for (int k = 0; k < lanes; k++) begin
                if (write_mask[k]) begin
                    mem[address][k*lane_bits +: lane_bits] <= data_in[k*lane_bits +: lane_bits];
                end
            end
        end
    end

    // Registered read path: one-cycle latency, data_out holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= accept && !write_enable;
            if (accept && !write_enable) begin
                data_out <= mem[address];
            end
        end
    end

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync (addr_bits=4, data_bits=32, lane_bits=8).
// Honours RAM_INIT_CLEAR_EN the same way as the design.
module tb_ram_sync;

    localparam int          addr_bits = 4;
    localparam int          data_bits = 32;
    localparam int          lane_bits = 8;
    localparam int          lanes     = data_bits / lane_bits;
    localparam int          depth     = 1 << addr_bits;
    localparam logic [31:0] fill      = 32'hC3C3_5A5A;

`ifdef RAM_INIT_CLEAR_EN
    localparam bit feature_on = 1'b1;
`else
    localparam bit feature_on = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 req = 1'b0;
    logic                 write_enable = 1'b0;
    logic [addr_bits-1:0] address = '0;
    logic [data_bits-1:0] data_in = '0;
    logic [lanes-1:0]     write_mask = '0;
    logic                 ready;
    logic                 busy;
    logic [data_bits-1:0] data_out;
    logic                 data_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [depth];

    ram_sync #(
        .addr_bits  (addr_bits),
        .data_bits  (data_bits),
        .lane_bits  (lane_bits),
        .fill_value (fill)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .write_mask   (write_mask),
        .ready        (ready),
        .busy         (busy),
        .data_out     (data_out),
        .data_valid   (data_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    // Byte-lane merge of a write into a stored word.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < lanes; k++)
            if (m[k]) r[k*8 +: 8] = nw[k*8 +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        req = 1'b0;
        write_enable = 1'b0;
    endtask

    // Accepted write (assumes ready), keeping the model in step.
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        req = 1'b1; write_enable = 1'b1; address = a; data_in = d; write_mask = m;
        step();
        model[a] = merge(model[a], d, m);
        idle();
    endtask

    task automatic rd_issue(input logic [3:0] a);
        req = 1'b1; write_enable = 1'b0; address = a;
        data_in = $urandom; write_mask = 4'($urandom);
        step();
    endtask

    // Counts edges until ready is seen high, and cycles where busy was not high while waiting.
    task automatic wait_ready(output int cycles, output int busy_bad);
        cycles = 0;
        busy_bad = 0;
        while (ready !== 1'b1 && cycles < 100) begin
            if (busy !== 1'b1) busy_bad++;
            step();
            cycles++;
        end
    endtask

    task automatic after_sweep();
        if (feature_on)
            for (int i = 0; i < depth; i++) model[i] = fill;
    endtask

    task automatic test_reset();
        int cyc, bb;
        idle();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (data_out !== 32'h0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: data_out=%h data_valid=%b, want 0/0", data_out, data_valid);
        end
        n_checks++;
        if (ready !== !feature_on || busy !== feature_on) begin
            n_fail++;
            $display("FAIL reset_ready_busy: ready=%b busy=%b, want %b/%b", ready, busy, !feature_on, feature_on);
        end
        reset = 1'b0;
        wait_ready(cyc, bb);
        n_checks++;
        if (cyc != (feature_on ? depth : 0) || bb != 0) begin
            n_fail++;
            $display("FAIL sweep_length: cycles=%0d busy_low=%0d, want %0d/0", cyc, bb, feature_on ? depth : 0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_sweep: busy=%b, want 0", busy);
        end
        after_sweep();
    endtask

    // Every address read back-to-back; without the sweep the array is written first.
    task automatic test_sweep_readback();
        if (!feature_on)
            for (int a = 0; a < depth; a++) wr(4'(a), $urandom, 4'hF);
        for (int a = 0; a < depth; a++) begin
            rd_issue(4'(a));
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== model[a]) begin
                n_fail++;
                $display("FAIL readback[%0d]: valid=%b data=%h, want 1/%h", a, data_valid, data_out, model[a]);
            end
        end
        idle();
        step();
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== model[depth-1]) begin
            n_fail++;
            $display("FAIL readback_end: valid=%b data=%h, want 0/%h", data_valid, data_out, model[depth-1]);
        end
    endtask

    task automatic test_write_read();
        req = 1'b1; write_enable = 1'b1; address = 4'd3; data_in = 32'h0000_00A5; write_mask = 4'hF;
        step();
        model[3] = merge(model[3], 32'h0000_00A5, 4'hF);
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_valid: valid=%b, want 0", data_valid);
        end
        rd_issue(4'd3);
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL write_read_a5: valid=%b data=%h, want 1/000000a5", data_valid, data_out);
        end
        idle();
        step();
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== 32'h0000_00A5) begin
            n_fail++;
            $display("FAIL write_read_hold: valid=%b data=%h, want 0/000000a5", data_valid, data_out);
        end
    endtask

    task automatic test_lane_mask();
        wr(4'd7, 32'h1122_3344, 4'b1111);
        wr(4'd7, 32'hAABB_CCDD, 4'b0101);
        wr(4'd7, 32'hFFFF_FFFF, 4'b0000);
        rd_issue(4'd7);
        idle();
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL lane_mask: valid=%b data=%h, want 1/11bb33dd", data_valid, data_out);
        end
    endtask

    // A write held on the port for the whole sweep must be ignored.
    task automatic test_req_during_sweep();
        int cyc;
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 1'b1; write_enable = 1'b1; address = 4'd5; data_in = ~fill; write_mask = 4'hF;
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        idle();
        after_sweep();
        n_checks++;
        if (cyc != depth) begin
            n_fail++;
            $display("FAIL req_sweep_len: cycles=%0d, want %0d", cyc, depth);
        end
        rd_issue(4'd5);
        idle();
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== fill) begin
            n_fail++;
            $display("FAIL req_sweep_ignored: valid=%b data=%h, want 1/%h", data_valid, data_out, fill);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc, bb;
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (9) step();
        n_checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_state: ready=%b busy=%b, want 0/1", ready, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready(cyc, bb);
        after_sweep();
        n_checks++;
        if (cyc != depth || bb != 0) begin
            n_fail++;
            $display("FAIL mid_sweep_restart: cycles=%0d busy_low=%0d, want %0d/0", cyc, bb, depth);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp = '{32'h10, 32'h20, 32'h30};
        for (int i = 0; i < 3; i++) wr(4'(i + 1), exp[i], 4'hF);
        for (int i = 0; i < 3; i++) begin
            rd_issue(4'(i + 1));
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: valid=%b data=%h, want 1/%h", i, data_valid, data_out, exp[i]);
            end
        end
        idle();
        step();
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== 32'h30) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b data=%h, want 0/00000030", data_valid, data_out);
        end
    endtask

    task automatic test_reset_after_read();
        int cyc, bb;
        wr(4'd9, 32'hDEAD_BEEF, 4'hF);
        rd_issue(4'd9);
        idle();
        reset = 1'b1;
        step();
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_after_read: valid=%b data=%h, want 0/0", data_valid, data_out);
        end
        reset = 1'b0;
        wait_ready(cyc, bb);
        after_sweep();
    endtask

    // Random mix of idle cycles, masked writes and reads against the array model.
    task automatic test_random();
        logic [31:0] exp_out;
        logic        r, w;
        logic [3:0]  a, m;
        logic [31:0] d;
        int          bad;
        exp_out = data_out;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(3) != 0);
            w = 1'($urandom);
            a = 4'($urandom);
            d = $urandom;
            m = 4'($urandom);
            req = r; write_enable = w; address = a; data_in = d; write_mask = m;
            step();
            if (r && w) model[a] = merge(model[a], d, m);
            if (r && !w) exp_out = model[a];
            n_checks++;
            if (data_valid !== (r && !w) || data_out !== exp_out) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: valid=%b data=%h, want %b/%h", i, data_valid, data_out, r && !w, exp_out);
            end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < depth; i++) model[i] = '0;
        test_reset();
        test_sweep_readback();
        test_write_read();
        test_lane_mask();
        if (feature_on) begin
            test_req_during_sweep();
            test_reset_mid_sweep();
            test_sweep_readback();
        end
        test_back_to_back();
        test_reset_after_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
